// File: rtl/poly_mult_pkg.sv
// Shared types and constants for the poly_mult sparse operand path.
// Lane format: bit 15 = dummy flag, bits 14:0 = position.
package poly_mult_pkg;

    localparam int LANE_W     = 16;
    localparam int LANES      = 8;
    localparam int DUMMY_BIT  = 15;
    localparam int N          = 17669;
    localparam int WEIGHT     = 66;
    localparam int MAX_WEIGHT = 75;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [14:0] N_POS     = 15'(N);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        LOAD,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    function automatic logic [LANE_W-1:0] pack_lane(
        input logic        dummy,
        input logic [14:0] pos
    );
        logic [LANE_W-1:0] l;
        l            = '0;
        l[DUMMY_BIT] = dummy;
        l[14:0]      = pos;
        return l;
    endfunction

    function automatic logic [14:0] lane_pos(input logic [LANE_W-1:0] l);
        return l[14:0];
    endfunction

    function automatic logic lane_is_dummy(input logic [LANE_W-1:0] l);
        return l[DUMMY_BIT];
    endfunction

endpackage

// File: rtl/dummy_lfsr.sv
// Galois LFSR (x^16+x^14+x^13+x^11+1) producing dummy positions.
// Only instantiated when DUMMY_INSERT_EN is defined.
module dummy_lfsr
    import poly_mult_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic        lsb,
    output logic [14:0] pos
);

    logic [15:0] lfsr;
    logic [15:0] nxt;

    // right-shifting Galois step, tap mask for the chosen polynomial
    always_comb begin
        nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // zero seed would lock the LFSR, so substitute the default
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (load) begin
            lfsr <= (seed == 16'h0000) ? LFSR_SEED : seed;
        end else if (advance) begin
            lfsr <= nxt;
        end
    end

    assign lsb = lfsr[0];
    // 2^15 < 2N, so one conditional subtraction lands in 0..N-1
    assign pos = (lfsr[14:0] < N_POS) ? lfsr[14:0] : lfsr[14:0] - N_POS;

endmodule

// File: rtl/sparse_pos_packer.sv
// Packs real (and optionally dummy) positions into 8-lane loader words.
// Dummy interleaving is enabled by defining DUMMY_INSERT_EN.
module sparse_pos_packer
    import poly_mult_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [15:0]   seed_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [14:0]   in_pos_i,
    output logic          load_o,
    output logic [127:0]  key_o,
    output logic [127:0]  data_o,
    input  logic          busy_i,
    output logic          active_o,
    output logic          done_o,
    output logic          err_o
);

    state_t      state;
    logic [6:0]  slot;
    logic [2:0]  lane;
    logic [6:0]  real_left;
    logic [6:0]  dummy_left;
    logic        lfsr_bit;
    logic [14:0] lfsr_pos;
    logic        start_ok;
    logic        pick_dummy;
    logic        fire;
    logic        pos_bad;
    logic [15:0] lane_val;

    assign start_ok = (state == IDLE) && start_i;

`ifdef DUMMY_INSERT_EN
    localparam logic [6:0] TOTAL_SLOTS = 7'(MAX_WEIGHT);

    dummy_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (start_ok),
        .seed    (seed_i),
        .advance (fire),
        .lsb     (lfsr_bit),
        .pos     (lfsr_pos)
    );
`else
    localparam logic [6:0] TOTAL_SLOTS = 7'(WEIGHT);

    logic unused_seed;
    assign unused_seed = ^seed_i;
    assign lfsr_bit    = 1'b0;
    assign lfsr_pos    = '0;
`endif

    localparam logic [6:0] DUMMY_SLOTS = TOTAL_SLOTS - 7'(WEIGHT);

    // slot type: forced when one pool is empty, else the LFSR decides
    always_comb begin
        pick_dummy = 1'b0;
        if (real_left != 7'd0 && dummy_left == 7'd0) begin
            pick_dummy = 1'b0;
        end else if (real_left == 7'd0 && dummy_left != 7'd0) begin
            pick_dummy = 1'b1;
        end else begin
            pick_dummy = lfsr_bit;
        end
    end

    assign in_ready_o = (state == FILL) && !pick_dummy;
    assign fire       = (state == FILL) && (pick_dummy || in_valid_i);
    assign pos_bad    = in_pos_i >= N_POS;
    assign lane_val   = pick_dummy ? pack_lane(1'b1, lfsr_pos)
                                   : pack_lane(pos_bad, in_pos_i);

    // frame FSM; data_o/key_o double as the word buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            slot       <= '0;
            lane       <= '0;
            real_left  <= '0;
            dummy_left <= '0;
            load_o     <= 1'b0;
            key_o      <= '0;
            data_o     <= '0;
            active_o   <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            load_o <= 1'b0;
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= FILL;
                        slot       <= '0;
                        lane       <= '0;
                        real_left  <= 7'(WEIGHT);
                        dummy_left <= DUMMY_SLOTS;
                        err_o      <= 1'b0;
                        data_o     <= '0;
                        key_o      <= '0;
                        active_o   <= 1'b1;
                    end
                end
                FILL: begin
                    if (fire) begin
                        data_o[{lane, 4'b0000} +: LANE_W] <= lane_val;
                        slot <= slot + 7'd1;
                        lane <= lane + 3'd1;
                        if (pick_dummy) begin
                            dummy_left <= dummy_left - 7'd1;
                        end else begin
                            real_left <= real_left - 7'd1;
                            if (pos_bad) err_o <= 1'b1;
                        end
                        if (lane == 3'd7 || slot + 7'd1 == TOTAL_SLOTS) begin
                            state  <= LOAD;
                            load_o <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (busy_i) state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!busy_i) begin
                        if (slot == TOTAL_SLOTS) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            data_o <= '0;
                            key_o  <= '0;
                        end else begin
                            state  <= FILL;
                            lane   <= '0;
                            data_o <= '0;
                            key_o  <= {121'b0, slot};
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    active_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
